fc_layer_ctrl: RTL and testbench
================================

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one activation byte.
REQ-002 Parameter IN, default 128: number of activations per input frame.
REQ-003 Parameter OUT, default 10: number of neuron (layer) instances sequenced in parallel.
REQ-004 Parameter RES_W, default 22: width of each neuron result.
REQ-005 Parameter SETTLE, default 2, legal range 1..15: cycles allowed for the combinational multiply/adder-tree/ReLU path.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port flush, input, 1: synchronous abort; returns the block to LOAD.
REQ-009 Port in_valid, input, 1: in_data is valid this cycle.
REQ-010 Port in_ready, output, 1: the block accepts in_data this cycle.
REQ-011 Port in_data, input, WIDTH: one activation, in frame order from index 0 to IN-1.
REQ-012 Port x_out, output, WIDTH*IN: flat activation buffer driven to all neuron x inputs; element i occupies bits [i*WIDTH +: WIDTH].
REQ-013 Port z_in, input, RES_W*OUT: flat neuron results; neuron j occupies bits [j*RES_W +: RES_W].
REQ-014 Port out_valid, output, 1: out_data is valid.
REQ-015 Port out_ready, input, 1: the downstream stage accepts out_data.
REQ-016 Port out_data, output, RES_W: the captured result of neuron out_idx.
REQ-017 Port out_idx, output, $clog2(OUT): the neuron index of out_data.
REQ-018 Port out_last, output, 1: high with out_valid when out_idx equals OUT-1.
REQ-019 Port busy, output, 1: high in every state except LOAD while wr_ptr equals 0.

Function
REQ-020 The FSM SHALL have four states: LOAD, SETTLE, CAPTURE and DRAIN.
REQ-021 LOAD: in_ready SHALL be 1; on each in_valid&&in_ready the block SHALL write buf[wr_ptr]=in_data and increment wr_ptr.
REQ-022 When the beat at wr_ptr==IN-1 is accepted, the FSM SHALL move to SETTLE, set wr_ptr to 0 and clear settle_cnt.
REQ-023 SETTLE: in_ready SHALL be 0; settle_cnt SHALL increment each cycle; after SETTLE cycles the FSM SHALL move to CAPTURE.
REQ-024 CAPTURE: the block SHALL register all OUT slices of z_in into its result registers in a single cycle, set rd_ptr to 0 and move to DRAIN.
REQ-025 DRAIN: out_valid SHALL be 1; out_data SHALL equal res[rd_ptr] and out_idx SHALL equal rd_ptr.
REQ-026 On out_valid&&out_ready the block SHALL increment rd_ptr; out_valid SHALL remain asserted with stable data while out_ready is low.
REQ-027 On the handshake with out_last high, the FSM SHALL move to LOAD in the next cycle; there SHALL be no out_valid bubble between results 0..OUT-1.
REQ-028 x_out SHALL be driven directly from buf; buf SHALL change only on accepted LOAD beats, so x_out is stable throughout SETTLE, CAPTURE and DRAIN.
REQ-029 Minimum latency from the last input beat to the first out_valid SHALL be SETTLE+2 cycles.
REQ-030 Result registers SHALL be loaded only in CAPTURE; changes on z_in at any other time SHALL NOT affect out_data.
REQ-031 flush SHALL force LOAD, set wr_ptr and rd_ptr to 0 and clear out_valid in the next cycle, from any state.
REQ-032 flush SHALL leave buf and the result registers unchanged.
REQ-033 flush SHALL take priority over a same-cycle input or output handshake; that beat SHALL NOT be counted.
REQ-034 No arithmetic SHALL be performed on the data; results SHALL be passed through bit-exact.

Reset
REQ-035 When rst is asserted, the block SHALL asynchronously enter LOAD and set wr_ptr, rd_ptr and settle_cnt to 0.
REQ-036 During reset, out_valid SHALL be 0, in_ready SHALL be 1 once reset is released, and busy SHALL be 0.
REQ-037 Reset SHALL clear buf and the result registers to 0, so x_out=0 and out_data=0 after reset.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame and any undrained results.

Verification
REQ-039 Stream 128 beats in_data=i&0xFF with in_valid held high and SETTLE=2, drive z_in slice j=j+100, keep out_ready=1 -> first out_valid appears 4 cycles after the last beat; outputs are 100..109 on idx 0..9; out_last is high only on idx 9.
REQ-040 Insert random gaps in in_valid -> buf contents match i; in_ready stays 1 until beat 127, then drops to 0.
REQ-041 Hold out_ready=0 for 5 cycles at idx 3, and change z_in during DRAIN -> out_data and out_idx stay at idx 3 with stable values; captured values are unaffected.
REQ-042 Assert flush at beat 60 -> in the next cycle the block is in LOAD with wr_ptr=0; the following 128-beat frame completes normally.
REQ-043 Assert rst asynchronously during DRAIN -> out_valid drops to 0 immediately, x_out=0 and busy=0.
REQ-044 Run back-to-back frames with the second frame presented during DRAIN -> in_ready=0 until the last result handshake; beat 0 of the second frame is accepted in the first LOAD cycle.

Source files
------------

// File: rtl/fc_layer_ctrl.sv
// Sequencer for a fully-connected layer: buffers one activation frame, waits for the
// combinational neuron array to settle, captures all neuron results, then streams them out.
module fc_layer_ctrl #(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int OUT    = 10,
    parameter int RES_W  = 22,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic [WIDTH*IN-1:0]    x_out,
    input  logic [RES_W*OUT-1:0]   z_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RES_W-1:0]       out_data,
    output logic [$clog2(OUT)-1:0] out_idx,
    output logic                   out_last,
    output logic                   busy
);

    localparam int PTR_W = (IN > 1) ? $clog2(IN) : 1;
    localparam int IDX_W = $clog2(OUT);
    localparam int CNT_W = 4;

    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(IN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(OUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic               wr_en;
    logic               cap_en;

    logic [WIDTH-1:0]   act_q [IN];
    logic [RES_W-1:0]   res_q [OUT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        settle_d  = settle_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wr_en     = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cap_en   = 1'b1;
                rd_ptr_d = '0;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
        // Abort wins over any handshake in the same cycle; data storage is left intact.
        if (flush) begin
            state_d  = S_LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            wr_en    = 1'b0;
            cap_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN; i++) begin
                act_q[i] <= '0;
            end
        end else if (wr_en) begin
            act_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < OUT; j++) begin
                res_q[j] <= '0;
            end
        end else if (cap_en) begin
            for (int j = 0; j < OUT; j++) begin
                res_q[j] <= z_in[j*RES_W +: RES_W];
            end
        end
    end

    for (genvar i = 0; i < IN; i++) begin : g_xout
        assign x_out[i*WIDTH +: WIDTH] = act_q[i];
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < OUT; j++) begin
            if (rd_ptr_q == IDX_W'(j)) begin
                out_data = res_q[j];
            end
        end
    end

    assign out_idx  = rd_ptr_q;
    assign out_last = out_valid && (rd_ptr_q == LAST_IDX);
    assign busy     = !((state_q == S_LOAD) && (wr_ptr_q == '0));

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed-random bench for fc_layer_ctrl: frames, stalls, flush, async reset and
// back-to-back traffic checked against a frame/result-level reference model.
module tb_fc_layer_ctrl;

    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int OUT    = 10;
    localparam int RES_W  = 22;
    localparam int SETTLE = 2;
    localparam int IDX_W  = $clog2(OUT);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [WIDTH*IN-1:0]  x_out;
    logic [RES_W*OUT-1:0] z_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [RES_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_buf [IN];
    logic [RES_W-1:0] exp_res [OUT];
    logic [WIDTH-1:0] frame   [IN];

    fc_layer_ctrl #(
        .WIDTH(WIDTH), .IN(IN), .OUT(OUT), .RES_W(RES_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .x_out(x_out), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_xout(input string tag);
        int nm;
        nm = 0;
        for (int i = 0; i < IN; i++) begin
            if (x_out[i*WIDTH +: WIDTH] !== exp_buf[i]) nm++;
        end
        chk(tag, nm, 0);
    endtask

    task automatic set_z_base(input int base);
        for (int j = 0; j < OUT; j++) z_in[j*RES_W +: RES_W] = RES_W'(base + j);
    endtask

    task automatic set_z_random();
        for (int j = 0; j < OUT; j++) z_in[j*RES_W +: RES_W] = RES_W'($urandom);
    endtask

    task automatic snapshot_z();
        for (int j = 0; j < OUT; j++) exp_res[j] = z_in[j*RES_W +: RES_W];
    endtask

    task automatic random_frame();
        for (int i = 0; i < IN; i++) frame[i] = WIDTH'($urandom);
    endtask

    task automatic send_frame(input int gap_max, input bit prestarted);
        int lowrdy;
        int g;
        lowrdy = 0;
        for (int i = 0; i < IN; i++) begin
            if (!(prestarted && i == 0)) begin
                g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                in_valid = 1'b0;
                repeat (g) begin
                    tick();
                    if (!in_ready) lowrdy++;
                end
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            if (!in_ready) lowrdy++;
            else exp_buf[i] = frame[i];
            tick();
            if (prestarted && i == 0) begin
                chk("b2b_beat0_taken_busy", busy, 1);
                chk("b2b_beat0_in_ready", in_ready, 1);
            end
        end
        in_valid = 1'b0;
        chk("in_ready_during_frame", lowrdy, 0);
        chk("in_ready_after_last", in_ready, 0);
        chk("busy_after_last", busy, 1);
        chk("no_valid_after_last", out_valid, 0);
    endtask

    task automatic wait_first_result();
        int n;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("first_result_latency", n, SETTLE + 2);
    endtask

    task automatic drain(input int stall_idx, input int stall_len, input int flush_at,
                         input int rst_at);
        out_ready = 1'b1;
        for (int k = 0; k < OUT; k++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_idx", out_idx, k);
            chk("drain_data", out_data, exp_res[k]);
            chk("drain_last", out_last, (k == OUT - 1));
            chk("drain_in_ready", in_ready, 0);
            if (k == flush_at) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                chk("flush_valid", out_valid, 0);
                chk("flush_idx", out_idx, 0);
                chk("flush_res_kept", out_data, exp_res[0]);
                chk("flush_busy", busy, 0);
                chk("flush_in_ready", in_ready, 1);
                check_xout("flush_drain_xout");
                return;
            end
            if (k == rst_at) begin
                #3;
                rst = 1'b1;
                #1;
                for (int i = 0; i < IN; i++) exp_buf[i] = '0;
                for (int j = 0; j < OUT; j++) exp_res[j] = '0;
                chk("rst_async_valid", out_valid, 0);
                chk("rst_async_busy", busy, 0);
                chk("rst_async_data", out_data, 0);
                check_xout("rst_async_xout");
                @(posedge clk);
                #1;
                rst = 1'b0;
                tick();
                chk("rst_release_in_ready", in_ready, 1);
                chk("rst_release_valid", out_valid, 0);
                chk("rst_release_idx", out_idx, 0);
                return;
            end
            if (k == stall_idx) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    set_z_random();
                    tick();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_idx", out_idx, k);
                    chk("stall_data", out_data, exp_res[k]);
                end
                out_ready = 1'b1;
            end
            set_z_random();
            tick();
        end
        chk("after_drain_valid", out_valid, 0);
        chk("after_drain_in_ready", in_ready, 1);
        chk("after_drain_busy", busy, 0);
        check_xout("after_drain_xout");
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; z_in = '0;
        for (int i = 0; i < IN; i++) exp_buf[i] = '0;
        for (int j = 0; j < OUT; j++) exp_res[j] = '0;
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", out_data, 0);
        chk("reset_idx", out_idx, 0);
        check_xout("reset_xout");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("reset_in_ready", in_ready, 1);

        // Frame A: ramp data, z slices 100.., free-flowing output
        for (int i = 0; i < IN; i++) frame[i] = WIDTH'(i & 8'hFF);
        set_z_base(100);
        send_frame(0, 1'b0);
        check_xout("frameA_xout");
        snapshot_z();
        wait_first_result();
        drain(-1, 0, -1, -1);

        // Frame B: random gaps, stall at idx 3 while z changes
        random_frame();
        set_z_random();
        send_frame(3, 1'b0);
        check_xout("frameB_xout");
        snapshot_z();
        wait_first_result();
        drain(3, 5, -1, -1);

        // Flush at beat 60, then a full frame, then flush mid-drain
        random_frame();
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_data = frame[i];
            exp_buf[i] = frame[i];
            tick();
        end
        flush = 1'b1;
        in_data = frame[60];
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_load_busy", busy, 0);
        chk("flush_load_in_ready", in_ready, 1);
        chk("flush_load_valid", out_valid, 0);
        check_xout("flush_load_xout");
        random_frame();
        set_z_random();
        send_frame(1, 1'b0);
        check_xout("post_flush_xout");
        snapshot_z();
        wait_first_result();
        drain(-1, 0, 5, -1);

        // Back-to-back: next frame's beat 0 presented during drain
        random_frame();
        set_z_random();
        send_frame(0, 1'b0);
        snapshot_z();
        wait_first_result();
        random_frame();
        in_valid = 1'b1;
        in_data  = frame[0];
        drain(-1, 0, -1, -1);
        set_z_random();
        send_frame(0, 1'b1);
        check_xout("b2b_xout");
        snapshot_z();
        wait_first_result();
        drain(6, 2, -1, -1);

        // Asynchronous reset during drain, then a clean frame
        random_frame();
        set_z_random();
        send_frame(2, 1'b0);
        snapshot_z();
        wait_first_result();
        drain(-1, 0, -1, 4);
        random_frame();
        set_z_random();
        send_frame(0, 1'b0);
        check_xout("final_xout");
        snapshot_z();
        wait_first_result();
        drain(9, 3, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
